conv_column_feeder: RTL
=======================

Name: conv_column_feeder

Overview:
- Producer side of the multi-channel 3x3 systolic convolution array.
- Accepts a raster-order multi-channel pixel stream and buffers two image rows per channel in line buffers.
- Emits one packed 3-pixel vertical column per channel per accepted pixel, sequencing the array's load_weight / col / start_conv controls per frame.
- Sits between the frame DMA/pixel source and the convolution array.

Parameters:
- DATA_WIDTH, 8, bits per pixel and per channel.
- NUM_CHANNELS, 64, channels carried in parallel per pixel.
- IMG_WIDTH, 16, pixels per row; legal range 3 to 1024.
- IMG_HEIGHT, 16, rows per frame; legal range 3 to 1024.
- DRAIN_CYCLES, 220, cycles start_conv stays high after the last column.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- frame_start  in  1  one-cycle request to begin a frame; ignored unless IDLE.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  feeder can accept a pixel.
- pix_data  in  NUM_CHANNELS*DATA_WIDTH  one pixel, all channels; channel i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- load_weight  out  1  one-cycle weight-latch strobe to the array.
- col  out  1  input_col valid strobe.
- input_col  out  NUM_CHANNELS*3*DATA_WIDTH  packed columns; channel i at [(i+1)*3*DATA_WIDTH-1 -: 3*DATA_WIDTH] = {row y-2, row y-1, row y}, with row y-2 in the MS byte.
- start_conv  out  1  array accumulate enable.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at end of DRAIN.

Behaviour:
- Reset: all outputs 0, state IDLE; x and y counters 0; line buffers are not required to be cleared.
- A pixel is accepted when pix_valid && pix_ready in the same cycle. The pixel source may hold pix_valid with stable data indefinitely.
- Counters on acceptance:
  - x increments; at IMG_WIDTH-1, x wraps to 0 and y increments.
  - Line buffers lb0[x], lb1[x] hold rows y-2 and y-1 at column x.
  - Per acceptance: lb0[x] <= lb1[x]; lb1[x] <= pix_data.
- State IDLE:
  - pix_ready=0, busy=0.
  - frame_start -> LOAD_W.
- State LOAD_W:
  - Lasts exactly 1 cycle with load_weight=1, then -> FILL.
  - x and y cleared on entry.
- State FILL (y < 2):
  - pix_ready=1, col=0.
  - Acceptance of pixel (IMG_WIDTH-1, 1) -> STREAM.
- State STREAM (2 <= y < IMG_HEIGHT):
  - pix_ready=1.
  - On acceptance of (x,y): the next cycle has col=1 and input_col = {lb0[x], lb1[x], pix_data} per channel, using pre-update buffer values. Latency from acceptance to col is 1 cycle.
  - col=0 in cycles with no acceptance; input_col holds its last value.
  - start_conv goes 1 in the same cycle as the first col and remains 1 through DRAIN.
  - Acceptance of (IMG_WIDTH-1, IMG_HEIGHT-1) -> DRAIN.
- State DRAIN:
  - pix_ready=0, start_conv=1, col=0.
  - The last column's col pulse occurs in the first DRAIN cycle.
  - A down-counter runs DRAIN_CYCLES cycles; on expiry, frame_done=1 for 1 cycle, start_conv=0, -> IDLE.
- Frame totals:
  - IMG_HEIGHT*IMG_WIDTH pixels accepted.
  - (IMG_HEIGHT-2)*IMG_WIDTH col pulses.
  - Exactly one load_weight pulse and one frame_done pulse.
- Boundaries:
  - frame_start while busy is ignored.
  - frame_start in the same cycle as frame_done is ignored; a new frame_start is required.
  - rst mid-frame returns to IDLE immediately and drops all outputs to 0. The partial frame is discarded and no frame_done is issued.
  - pix_valid in IDLE or DRAIN is not accepted.
  - Row wrap carries no bubble: pixel (IMG_WIDTH-1,y) and (0,y+1) may be accepted in consecutive cycles.
- Widths: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits, and $clog2(DRAIN_CYCLES+1) bits for the drain counter; no arithmetic on pixel data.

Test Plan:
- Common setup: NUM_CHANNELS=2, IMG_WIDTH=4, IMG_HEIGHT=3, DRAIN_CYCLES=3. Channel c pixel = 16*y+x+128*c.
- Reset then idle: pix_valid=1 for 10 cycles with no frame_start -> pix_ready=0, col=0, busy=0.
- Nominal frame, pix_valid held 1 after frame_start:
  - load_weight pulses exactly 1 cycle.
  - 4 col pulses in consecutive cycles; the first column is ch0={0x00,0x10,0x20}, ch1={0x80,0x90,0xA0}.
  - The last column is ch0={0x03,0x13,0x23}.
  - start_conv is high 4+3 cycles; frame_done pulses once, then IDLE.
- Backpressure gaps: pix_valid toggled 1/0 every cycle -> the same 4 column values in order, col only the cycle after each acceptance, input_col stable between.
- Row-wrap correctness with IMG_HEIGHT=4: 8 cols; column (x=0,y=3) = {0x10,0x20,0x30} per ch0.
- Reset mid-STREAM after the 2nd col -> all outputs 0 immediately, no frame_done. A following frame_start yields a full clean frame of 4 correct columns.
- frame_start pulsed during FILL and during DRAIN -> ignored; exactly one load_weight and one frame_done per frame.

Source files
------------

// File: rtl/conv_column_feeder.sv
// Column feeder for the 3x3 systolic conv array.
// Buffers two rows per channel and emits one 3-pixel column per pixel.
module conv_column_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 64,
  parameter int IMG_WIDTH    = 16,
  parameter int IMG_HEIGHT   = 16,
  parameter int DRAIN_CYCLES = 220
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic pix_valid,
  output logic pix_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] pix_data,
  output logic load_weight,
  output logic col,
  output logic [NUM_CHANNELS*3*DATA_WIDTH-1:0] input_col,
  output logic start_conv,
  output logic busy,
  output logic frame_done
);

  localparam int PW = NUM_CHANNELS*DATA_WIDTH;
  localparam int CW = 3*DATA_WIDTH;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int DW = $clog2(DRAIN_CYCLES+1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH-1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT-1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [DW-1:0] D_INIT = DW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FILL,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DW-1:0] drain_cnt;
  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic accept;
  logic x_last;
  logic [NUM_CHANNELS*CW-1:0] col_next;

  assign accept = pix_valid && pix_ready;
  assign x_last = (x == X_LAST);

  // Column is built from pre-update buffer contents plus the live pixel.
  always_comb begin
    col_next = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      col_next[i*CW +: CW] = {lb0[x][i*DATA_WIDTH +: DATA_WIDTH],
                              lb1[x][i*DATA_WIDTH +: DATA_WIDTH],
                              pix_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[x] <= lb1[x];
      lb1[x] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      drain_cnt   <= '0;
      pix_ready   <= 1'b0;
      load_weight <= 1'b0;
      col         <= 1'b0;
      input_col   <= '0;
      start_conv  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      load_weight <= 1'b0;
      col         <= 1'b0;
      frame_done  <= 1'b0;
      if (accept) begin
        if (x_last) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      unique case (state)
        S_IDLE: begin
          // A start coinciding with frame_done belongs to the old frame.
          if (frame_start && !frame_done) begin
            state       <= S_LOAD_W;
            load_weight <= 1'b1;
            busy        <= 1'b1;
            x           <= '0;
            y           <= '0;
          end
        end
        S_LOAD_W: begin
          state     <= S_FILL;
          pix_ready <= 1'b1;
        end
        S_FILL: begin
          if (accept && x_last && y == Y_ONE) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            col        <= 1'b1;
            input_col  <= col_next;
            start_conv <= 1'b1;
            if (x_last && y == Y_LAST) begin
              state     <= S_DRAIN;
              pix_ready <= 1'b0;
              drain_cnt <= D_INIT;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
            start_conv <= 1'b0;
            busy       <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
